hasti_timem_bridge: RTL and testbench

- AHB-lite (HASTI) slave that initiates accesses on the tightly-integrated memory port: addr/read/write/size/wdata in, rdata returned one cycle later.
- Sits between the core's HASTI data bus and the single-port TIM.
- Aligns AHB address/data phases to the memory's one-cycle synchronous read and same-cycle write.
- Resolves the port collision between a write data phase and a following read address phase with a one-cycle stall.

---
 rtl/hasti_timem_bridge.sv | 134 +++++++++++++
 tb/tb_hasti_timem_bridge.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hasti_timem_bridge.sv
// HASTI (AHB-lite) slave bridging the core data bus onto the single-port TIM.
// Optional address/alignment checking with a two-cycle ERROR response: HASTI_TIMEM_RANGE_CHECK_EN.
module hasti_timem_bridge #(
    parameter int unsigned MEM_BYTES_LOG2 = 14,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [1:0]  htrans,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic        hresp,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_size,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

`ifdef HASTI_TIMEM_RANGE_CHECK_EN
    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RD_STALL, S_ERR1, S_ERR2} state_e;
`else
    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RD_STALL} state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  size_q, size_d;
    logic        ready_int;
    logic        acc;
    logic        bad;
    logic        unused_bits;

`ifdef HASTI_TIMEM_RANGE_CHECK_EN
    assign ready_int = (state_q != S_RD_STALL) && (state_q != S_ERR1);
`else
    assign ready_int = (state_q != S_RD_STALL);
`endif
    assign acc = ready_int & htrans[1];

`ifdef HASTI_TIMEM_RANGE_CHECK_EN
    always_comb begin
        bad = (haddr[31:MEM_BYTES_LOG2] != BASE_ADDR[31:MEM_BYTES_LOG2]);
        if (hsize == 3'd1 && haddr[0])
            bad = 1'b1;
        if (hsize == 3'd2 && haddr[1:0] != 2'b00)
            bad = 1'b1;
    end
    assign unused_bits = htrans[0];
`else
    assign bad         = 1'b0;
    assign unused_bits = ^{htrans[0], BASE_ADDR, 32'(MEM_BYTES_LOG2)};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
        end
    end

    // A read accepted while the write data phase owns the port is deferred one cycle.
    always_comb begin
        state_d = S_IDLE;
        addr_d  = addr_q;
        size_d  = size_q;
        if (acc && !bad) begin
            if (hwrite) begin
                state_d = S_WR;
                addr_d  = haddr;
                size_d  = hsize;
            end else if (state_q == S_WR) begin
                state_d = S_RD_STALL;
                addr_d  = haddr;
                size_d  = hsize;
            end else begin
                state_d = S_RD;
            end
        end
        if (state_q == S_RD_STALL)
            state_d = S_RD;
`ifdef HASTI_TIMEM_RANGE_CHECK_EN
        if (acc && bad)
            state_d = S_ERR1;
        if (state_q == S_ERR1)
            state_d = S_ERR2;
`endif
    end

    always_comb begin
        hready    = ready_int;
        hresp     = 1'b0;
        hrdata    = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_size  = '0;
        mem_wdata = '0;
        case (state_q)
            S_WR: begin
                mem_write = 1'b1;
                mem_addr  = addr_q;
                mem_size  = size_q;
                mem_wdata = hwdata;
            end
            S_RD: hrdata = mem_rdata;
            S_RD_STALL: begin
                mem_read = 1'b1;
                mem_addr = addr_q;
                mem_size = size_q;
            end
`ifdef HASTI_TIMEM_RANGE_CHECK_EN
            S_ERR1, S_ERR2: hresp = 1'b1;
`endif
            default: ;
        endcase
        if (acc && !bad && !hwrite && state_q != S_WR) begin
            mem_read = 1'b1;
            mem_addr = haddr;
            mem_size = hsize;
        end
    end

endmodule

// File: tb/tb_hasti_timem_bridge.sv
// Bench for hasti_timem_bridge: AHB master driving directed and random transfers
// against a TIM model, with a byte-level reference memory predicting read data.
module tb_hasti_timem_bridge;

    localparam int LOG2  = 14;
    localparam int WORDS = 1 << (LOG2 - 2);
`ifdef HASTI_TIMEM_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_size;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    hasti_timem_bridge #(.MEM_BYTES_LOG2(LOG2), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
        .htrans(htrans), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [31:0] tim     [0:WORDS-1];
    logic [31:0] ref_mem [0:WORDS-1];

    int checks = 0;
    int errors = 0;

    // Byte-lane merge of an AHB write of the given size into an aligned word.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] addr,
                                          input logic [2:0] size, input logic [31:0] data);
        logic [31:0] r;
        logic [3:0]  be;
        r = old;
        case (size)
            3'd0:    be = 4'b0001 << addr[1:0];
            3'd1:    be = 4'b0011 << {addr[1], 1'b0};
            default: be = 4'b1111;
        endcase
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    // TIM: synchronous read, same-cycle write.
    always @(posedge clk) begin
        if (mem_write)
            tim[mem_addr[LOG2-1:2]] <= merge(tim[mem_addr[LOG2-1:2]], mem_addr, mem_size, mem_wdata);
        if (mem_read)
            mem_rdata <= tim[mem_addr[LOG2-1:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    typedef struct {
        bit          trans;
        bit          busy;
        bit          write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        bit          err;
        bit          after_wr;
    } op_t;

    op_t ops[$];

    function automatic bit is_err(input logic [31:0] a, input logic [2:0] s);
        return RANGE_CHK && ((a[31:LOG2] != '0) || (s == 3'd1 && a[0]) ||
                             (s == 3'd2 && a[1:0] != 2'b00));
    endfunction

    function automatic op_t mk(input bit trans, input bit write, input logic [31:0] addr,
                               input logic [2:0] size, input logic [31:0] wdata);
        op_t o;
        o = '{default: 0};
        o.trans = trans;
        o.write = write;
        o.addr  = addr;
        o.size  = size;
        o.wdata = wdata;
        o.err   = trans && is_err(addr, size);
        return o;
    endfunction

    // Pipelined master: presents ops[0] as address phase while finishing the previous data phase.
    task automatic run_ops();
        op_t         cur, dp, idle_op;
        bit          dp_v;
        int          wcnt, cyc, limit;
        logic        exp_rdy, exp_rsp, exp_rd, exp_wr;
        logic [31:0] exp_addr;
        logic [2:0]  exp_size;
        idle_op = mk(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        dp      = idle_op;
        dp_v    = 1'b0;
        wcnt    = 0;
        cyc     = 0;
        limit   = 4 * ops.size() + 20;
        while (ops.size() > 0 || dp_v) begin
            cur    = (ops.size() > 0) ? ops[0] : idle_op;
            haddr  = cur.addr;
            hwrite = cur.write;
            hsize  = cur.size;
            htrans = cur.trans ? 2'b10 : (cur.busy ? 2'b01 : 2'b00);
            hwdata = (dp_v && dp.write) ? dp.wdata : $urandom();
            @(negedge clk);
            exp_rdy  = 1'b1;
            exp_rsp  = 1'b0;
            exp_rd   = 1'b0;
            exp_wr   = 1'b0;
            exp_addr = '0;
            exp_size = '0;
            if (dp_v) begin
                if (dp.err) begin
                    exp_rsp = 1'b1;
                    exp_rdy = (wcnt != 0);
                end else if (dp.write) begin
                    exp_wr   = 1'b1;
                    exp_addr = dp.addr;
                    exp_size = dp.size;
                end else if (dp.after_wr && wcnt == 0) begin
                    exp_rdy  = 1'b0;
                    exp_rd   = 1'b1;
                    exp_addr = dp.addr;
                    exp_size = dp.size;
                end
            end
            if (exp_rdy && cur.trans && !cur.write && !cur.err && !(dp_v && dp.write && !dp.err)) begin
                exp_rd   = 1'b1;
                exp_addr = cur.addr;
                exp_size = cur.size;
            end
            chk("hready", 32'(hready), 32'(exp_rdy));
            chk("hresp", 32'(hresp), 32'(exp_rsp));
            chk("mem_read", 32'(mem_read), 32'(exp_rd));
            chk("mem_write", 32'(mem_write), 32'(exp_wr));
            if (exp_rd || exp_wr) begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_size", 32'(mem_size), 32'(exp_size));
            end
            if (exp_wr)
                chk("mem_wdata", mem_wdata, dp.wdata);
            if (!dp_v || dp.write || dp.err)
                chk("hrdata_zero", hrdata, 32'h0);
            if (dp_v && !dp.write && !dp.err && hready)
                chk("hrdata", hrdata, ref_mem[dp.addr[LOG2-1:2]]);
            if (dp_v && dp.write && !dp.err && hready)
                ref_mem[dp.addr[LOG2-1:2]] = merge(ref_mem[dp.addr[LOG2-1:2]], dp.addr, dp.size, dp.wdata);
            if (hready) begin
                if (cur.trans) begin
                    cur.after_wr = dp_v && dp.write && !dp.err;
                    dp   = cur;
                    dp_v = 1'b1;
                end else begin
                    dp_v = 1'b0;
                end
                if (ops.size() > 0)
                    void'(ops.pop_front());
                wcnt = 0;
            end else begin
                wcnt++;
            end
            cyc++;
            if (cyc > limit) begin
                chk("cycle_budget", 32'(cyc), 32'(limit));
                ops.delete();
                dp_v = 1'b0;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] v, a;
        int          kind;
        logic [2:0]  sz;
        for (int i = 0; i < WORDS; i++) begin
            v          = $urandom();
            tim[i]     = v;
            ref_mem[i] = v;
        end
        reset  = 1'b1;
        haddr  = '0;
        hwrite = 1'b0;
        hsize  = '0;
        htrans = 2'b00;
        hwdata = '0;

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hready", 32'(hready), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_hrdata", hrdata, 32'h0);

        // Reset asserted while a write to 0x10 is in its data phase: the write is dropped.
        @(posedge clk);
        #1;
        reset  = 1'b0;
        haddr  = 32'h10;
        hwrite = 1'b1;
        hsize  = 3'd2;
        htrans = 2'b10;
        @(posedge clk);
        #1;
        htrans = 2'b00;
        hwrite = 1'b0;
        hwdata = 32'hDEAD_BEEF;
        #2;
        chk("wr_pending", 32'(mem_write), 32'd1);
        chk("wr_pending_addr", mem_addr, 32'h10);
        reset = 1'b1;
        #1;
        chk("rst_mid_wr_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mid_wr_hready", 32'(hready), 32'd1);
        chk("rst_mid_wr_hresp", 32'(hresp), 32'd0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed transfers.
        ops.push_back(mk(1, 0, 32'h10,  3'd2, 32'h0));
        ops.push_back(mk(1, 1, 32'h100, 3'd2, 32'h1234_5678));
        ops.push_back(mk(0, 0, 32'h0,   3'd0, 32'h0));
        ops.push_back(mk(1, 0, 32'h100, 3'd2, 32'h0));
        ops.push_back(mk(1, 1, 32'h200, 3'd2, 32'hCAFE_F00D));
        ops.push_back(mk(1, 0, 32'h200, 3'd2, 32'h0));
        ops.push_back(mk(1, 1, 32'h303, 3'd0, 32'hAB00_0000));
        ops.push_back(mk(0, 0, 32'h0,   3'd0, 32'h0));
        ops.push_back(mk(1, 0, 32'h300, 3'd2, 32'h0));
        ops.push_back(mk(1, 0, 32'h0,   3'd2, 32'h0));
        ops.push_back(mk(1, 0, 32'h4,   3'd2, 32'h0));
        ops.push_back(mk(1, 0, 32'h8,   3'd2, 32'h0));
        if (RANGE_CHK) begin
            ops.push_back(mk(1, 0, 32'h8000, 3'd2, 32'h0));
            ops.push_back(mk(1, 0, 32'h102,  3'd2, 32'h0));
            ops.push_back(mk(1, 1, 32'h104,  3'd2, 32'h5A5A_0F0F));
            ops.push_back(mk(1, 0, 32'h8000, 3'd2, 32'h0));
            ops.push_back(mk(1, 0, 32'h104,  3'd2, 32'h0));
        end
        run_ops();

        // Random traffic over a small window to provoke write->read collisions.
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 9);
            sz   = 3'($urandom_range(0, 2));
            a    = 32'($urandom_range(0, 63)) << 2;
            if (sz == 3'd0) a[1:0] = 2'($urandom_range(0, 3));
            if (sz == 3'd1) a[1]   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a[31:LOG2] = 18'($urandom());
            if (RANGE_CHK && $urandom_range(0, 15) == 0) a[0] = 1'b1;
            if (kind <= 3)
                ops.push_back(mk(1, 1, a, sz, $urandom()));
            else if (kind <= 7)
                ops.push_back(mk(1, 0, a, sz, 32'h0));
            else begin
                ops.push_back(mk(0, 0, a, sz, 32'h0));
                ops[$].busy = (kind == 9);
            end
        end
        run_ops();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
